// File: rtl/change_pkg.sv
// Shared encodings for change_dispenser: FSM states, coin codes, coin values
// and stock-select codes.
package change_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_DONE
    } state_t;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_RS1  = 3'b001;
    localparam logic [2:0] COIN_RS2  = 3'b010;
    localparam logic [2:0] COIN_RS5  = 3'b101;

    localparam int VAL_RS1 = 1;
    localparam int VAL_RS2 = 2;
    localparam int VAL_RS5 = 5;

    localparam logic [1:0] SEL_RS1  = 2'd0;
    localparam logic [1:0] SEL_RS2  = 2'd1;
    localparam logic [1:0] SEL_RS5  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    function automatic logic [1:0] coin_sel(input logic [2:0] code);
        case (code)
            COIN_RS1: return SEL_RS1;
            COIN_RS2: return SEL_RS2;
            COIN_RS5: return SEL_RS5;
            default:  return SEL_NONE;
        endcase
    endfunction

    function automatic logic [2:0] coin_value(input logic [2:0] code);
        case (code)
            COIN_RS1: return 3'(VAL_RS1);
            COIN_RS2: return 3'(VAL_RS2);
            COIN_RS5: return 3'(VAL_RS5);
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_stock.sv
// Per-denomination coin stock: three counters with reset preload, overwrite
// load, a single decrement port and empty flags {Rs5, Rs2, Rs1}.
module coin_stock
    import change_pkg::*;
#(
    parameter int CNT_W      = 6,
    parameter int INIT_STOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [1:0]       load_sel,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             dec,
    input  logic [1:0]       dec_sel,
    output logic [2:0]       empty
);

    logic [CNT_W-1:0] cnt_rs1;
    logic [CNT_W-1:0] cnt_rs2;
    logic [CNT_W-1:0] cnt_rs5;

    // NOTE: sequential state uses non-blocking assignments so every counter
    // sees the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_rs1 <= CNT_W'(INIT_STOCK);
            cnt_rs2 <= CNT_W'(INIT_STOCK);
            cnt_rs5 <= CNT_W'(INIT_STOCK);
        end else if (load) begin
            case (load_sel)
                SEL_RS1: cnt_rs1 <= load_cnt;
                SEL_RS2: cnt_rs2 <= load_cnt;
                SEL_RS5: cnt_rs5 <= load_cnt;
                default: ;
            endcase
        end else if (dec) begin
            // The FSM only picks a denomination whose count is non-zero.
            case (dec_sel)
                SEL_RS1: cnt_rs1 <= cnt_rs1 - CNT_W'(1);
                SEL_RS2: cnt_rs2 <= cnt_rs2 - CNT_W'(1);
                SEL_RS5: cnt_rs5 <= cnt_rs5 - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign empty = {cnt_rs5 == '0, cnt_rs2 == '0, cnt_rs1 == '0};

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: issues Rs5/Rs2/Rs1 coins over a valid/ready
// handshake and reports any unpayable remainder. Macro COIN_TIMEOUT_EN adds an
// ISSUE-state watchdog that abandons a coin the hopper never takes.
module change_dispenser
    import change_pkg::*;
#(
    parameter int AMT_W      = 8,
    parameter int CNT_W      = 6,
    parameter int INIT_STOCK = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amt,
    output logic             coin_valid,
    input  logic             coin_ready,
    output logic [2:0]       coin_code,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remain,
    input  logic             load,
    input  logic [1:0]       load_sel,
    input  logic [CNT_W-1:0] load_cnt,
    output logic [2:0]       stock_empty
);

    state_t           state;
    state_t           state_nxt;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] rem_after;
    logic [AMT_W-1:0] remain_q;
    logic [2:0]       coin_q;
    logic [2:0]       pick;
    logic             accept;
    logic             handshake;
    logic             timeout_hit;

    assign accept    = (state == ST_IDLE) && req_valid;
    assign handshake = (state == ST_ISSUE) && coin_ready;
    assign rem_after = rem - AMT_W'(coin_value(coin_q));

    always_comb begin
        pick = COIN_NONE;
        if (rem >= AMT_W'(VAL_RS5) && !stock_empty[2]) begin
            pick = COIN_RS5;
        end else if (rem >= AMT_W'(VAL_RS2) && !stock_empty[1]) begin
            pick = COIN_RS2;
        end else if (rem >= AMT_W'(VAL_RS1) && !stock_empty[0]) begin
            pick = COIN_RS1;
        end
    end

`ifdef COIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE && !coin_ready) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_hit = (state == ST_ISSUE) && !coin_ready
                         && (wait_cnt == TW'(TIMEOUT - 1));
`else
    // Without the watchdog TIMEOUT has no effect and ISSUE waits forever.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rem      <= '0;
            remain_q <= '0;
            coin_q   <= COIN_NONE;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rem      <= req_amt;
                remain_q <= '0;
            end
            if (state == ST_SELECT) begin
                coin_q <= pick;
            end
            if (handshake) begin
                rem <= rem_after;
            end
            if (state == ST_DONE) begin
                remain_q <= rem;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        coin_valid = 1'b0;
        coin_code  = COIN_NONE;
        done       = 1'b0;
        short      = 1'b0;
        remain     = remain_q;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = (req_amt == '0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_SELECT: begin
                state_nxt = (pick == COIN_NONE) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                coin_valid = 1'b1;
                coin_code  = coin_q;
                if (coin_ready) begin
                    state_nxt = (rem_after == '0) ? ST_DONE : ST_SELECT;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                short     = (rem != '0);
                remain    = rem;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    coin_stock #(
        .CNT_W      (CNT_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk      (clk),
        .rst      (rst),
        .load     (load && (state == ST_IDLE)),
        .load_sel (load_sel),
        .load_cnt (load_cnt),
        .dec      (handshake),
        .dec_sel  (coin_sel(coin_q)),
        .empty    (stock_empty)
    );

endmodule
